mem_fillbuffer: RTL and testbench
=================================

MEM_FILLBUFFER -- requirements
Module: mem_fillbuffer

Interface
REQ-001 Parameter ADDRWIDTH, default 32, byte address width.
REQ-002 Parameter LOG2FILLDATAWIDTH, default 7, log2 of cache line width in bits (FILLDATAWIDTH = 2**LOG2FILLDATAWIDTH).
REQ-003 Parameter LOG2MEMDATAWIDTH, default 5, log2 of memory beat width in bits (MEMDATAWIDTH); BEATS = FILLDATAWIDTH/MEMDATAWIDTH, and BEATS >= 2 SHALL hold.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 filladdr  in  ADDRWIDTH  byte address of the missing word.
REQ-007 fillreq  in  1  request a line fill; sampled only when fillbusy=0.
REQ-008 fillbusy  out  1  high whenever the FSM is not IDLE.
REQ-009 mem_address  out  ADDRWIDTH  line-aligned read address.
REQ-010 mem_rden  out  1  read command valid.
REQ-011 mem_ack  in  1  memory accepted the read command.
REQ-012 mem_readdata  in  MEMDATAWIDTH  returned beat.
REQ-013 mem_readvalid  in  1  mem_readdata valid this cycle.
REQ-014 linedata  out  FILLDATAWIDTH  assembled line.
REQ-015 lineaddr  out  ADDRWIDTH  line-aligned address of linedata.
REQ-016 linevalid  out  1  linedata/lineaddr valid.
REQ-017 lineack  in  1  consumer accepted the line.

Function
REQ-018 FSM states SHALL be IDLE, REQ, COLLECT and DELIVER; at most one line is in flight at any time.
REQ-019 IDLE: when fillreq=1, the block SHALL register filladdr with its low LOG2FILLDATAWIDTH-3 bits cleared as the line address and enter REQ on the next edge.
REQ-020 REQ: mem_rden SHALL be 1 and mem_address SHALL equal the line address, both held stable until mem_ack=1; on mem_ack=1 the FSM SHALL enter COLLECT and the beat counter SHALL be cleared.
REQ-021 COLLECT: each cycle with mem_readvalid=1, beat k (k = counter value) SHALL be written to linedata[MEMDATAWIDTH*k +: MEMDATAWIDTH], so the first beat lands lowest, and the counter SHALL increment.
REQ-022 Beats may arrive with arbitrary gaps; the block SHALL NOT time out.
REQ-023 Capture of beat BEATS-1 SHALL move the FSM to DELIVER, with linevalid=1 on the following cycle; the beat counter wraps to 0.
REQ-024 DELIVER: linevalid=1; linedata and lineaddr SHALL be held stable until lineack=1, after which the FSM enters IDLE and linevalid=0 on the next cycle.
REQ-025 mem_readvalid outside COLLECT (including during REQ, and in the same cycle as mem_ack) SHALL be ignored.
REQ-026 fillreq while fillbusy=1 SHALL be ignored, including when it coincides with lineack in DELIVER; the requester must re-assert it.
REQ-027 lineack while linevalid=0 SHALL be ignored.
REQ-028 mem_rden SHALL be 0 outside REQ.
REQ-029 Minimum turnaround: fillreq to linevalid is 3 cycles plus ack latency plus beat latency.

Reset
REQ-030 While resetn=0 at an edge, the FSM SHALL enter IDLE; fillbusy, mem_rden, linevalid, mem_address, lineaddr, linedata and the beat counter SHALL all become 0.
REQ-031 Reset in any state, including mid-COLLECT, SHALL abandon the line; beats of the abandoned read arriving afterwards SHALL be ignored (REQ-025).

Configuration
REQ-032 Macro FILLBUFFER_EARLYWORD_EN: when defined, the block SHALL add the outputs earlyword_valid (1 bit) and earlyword_data (MEMDATAWIDTH).
REQ-033 With the macro defined, earlyword_valid SHALL pulse for exactly one cycle, one cycle after capture of beat index filladdr[LOG2MEMDATAWIDTH-3 +: log2(BEATS)], and earlyword_data SHALL equal that beat; both outputs reset to 0.
REQ-034 With the macro undefined, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
All scenarios use MEMDATAWIDTH=32 and FILLDATAWIDTH=128, so BEATS=4.
REQ-035 Basic fill:
- Stimulus: fillreq with filladdr=0x1004; mem_ack 3 cycles after mem_rden rises; beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles.
- Response: mem_address=0x1000; after the last beat, linevalid=1, lineaddr=0x1000, linedata=0x44444444_33333333_22222222_11111111.
REQ-036 Gapped beats: same fill with mem_readvalid every third cycle -> identical linedata; linevalid rises exactly 1 cycle after the 4th beat.
REQ-037 Busy rejection: fillreq with filladdr=0x2000 during COLLECT -> fillbusy=1, no second mem_rden; after the line completes, mem_address never equals 0x2000.
REQ-038 Backpressure: lineack held low for 5 cycles -> linevalid, linedata and lineaddr stable; lineack=1 -> next cycle linevalid=0 and fillbusy=0.
REQ-039 Reset mid-fill: resetn=0 for 1 cycle after 2 beats, then 2 stray beats -> all outputs 0 and the stray beats are ignored; a new fill with filladdr=0x3000 then completes correctly.
REQ-040 Early word (macro defined): filladdr=0x1008 -> earlyword_valid pulses once with earlyword_data=0x33333333, 1 cycle after beat 2 is captured.

Source files
------------

// File: rtl/mem_fillbuffer.sv
// Cache line fill buffer: one line read at a time, beats assembled low-first, held until consumed.
// Optional FILLBUFFER_EARLYWORD_EN adds a one-cycle pulse carrying the originally requested word.
module mem_fillbuffer #(
  parameter int ADDRWIDTH         = 32,
  parameter int LOG2FILLDATAWIDTH = 7,
  parameter int LOG2MEMDATAWIDTH  = 5
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [ADDRWIDTH-1:0]                filladdr,
  input  logic                                fillreq,
  output logic                                fillbusy,
  output logic [ADDRWIDTH-1:0]                mem_address,
  output logic                                mem_rden,
  input  logic                                mem_ack,
  input  logic [(1<<LOG2MEMDATAWIDTH)-1:0]    mem_readdata,
  input  logic                                mem_readvalid,
  output logic [(1<<LOG2FILLDATAWIDTH)-1:0]   linedata,
  output logic [ADDRWIDTH-1:0]                lineaddr,
  output logic                                linevalid,
  input  logic                                lineack
`ifdef FILLBUFFER_EARLYWORD_EN
  ,
  output logic                                earlyword_valid,
  output logic [(1<<LOG2MEMDATAWIDTH)-1:0]    earlyword_data
`endif
);

  localparam int MEMW  = 1 << LOG2MEMDATAWIDTH;
  localparam int FILLW = 1 << LOG2FILLDATAWIDTH;
  localparam int BEATW = LOG2FILLDATAWIDTH - LOG2MEMDATAWIDTH;
  localparam int OFFW  = LOG2FILLDATAWIDTH - 3;
  localparam logic [ADDRWIDTH-1:0] LINE_MASK = {{(ADDRWIDTH-OFFW){1'b1}}, {OFFW{1'b0}}};

  typedef enum logic [1:0] {IDLE, REQ, COLLECT, DELIVER} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [ADDRWIDTH-1:0] line_addr;
  logic [FILLW-1:0]     line_data;
  logic [BEATW-1:0]     beat_cnt;
  logic                 beat_take;
  logic                 start;

  assign start     = (state == IDLE) && fillreq;
  assign beat_take = (state == COLLECT) && mem_readvalid;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fillreq) state_nxt = REQ;
      REQ:     if (mem_ack) state_nxt = COLLECT;
      COLLECT: if (mem_readvalid && (beat_cnt == '1)) state_nxt = DELIVER;
      DELIVER: if (lineack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fillbusy  = (state != IDLE);
    mem_rden  = (state == REQ);
    linevalid = (state == DELIVER);
  end

  assign mem_address = line_addr;
  assign lineaddr    = line_addr;
  assign linedata    = line_data;

  // Line registers only change in IDLE/COLLECT, so they are stable through REQ and DELIVER.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      line_addr <= '0;
      line_data <= '0;
      beat_cnt  <= '0;
    end else begin
      if (start) line_addr <= filladdr & LINE_MASK;
      if ((state == REQ) && mem_ack) begin
        beat_cnt <= '0;
      end else if (beat_take) begin
        line_data[int'(beat_cnt)*MEMW +: MEMW] <= mem_readdata;
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

`ifdef FILLBUFFER_EARLYWORD_EN
  logic [BEATW-1:0] early_idx;
  logic             early_hit;

  assign early_hit = beat_take && (beat_cnt == early_idx);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      early_idx       <= '0;
      earlyword_valid <= 1'b0;
      earlyword_data  <= '0;
    end else begin
      if (start) early_idx <= filladdr[LOG2MEMDATAWIDTH-3 +: BEATW];
      earlyword_valid <= early_hit;
      if (early_hit) earlyword_data <= mem_readdata;
    end
  end
`endif

endmodule

// File: tb/tb_mem_fillbuffer.sv
// Self-checking bench for mem_fillbuffer (32-bit beats, 128-bit lines); table of fills plus
// hand sequences for reset, busy rejection and backpressure, with a scoreboard of expected lines.
module tb_mem_fillbuffer;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [31:0]  filladdr = '0;
  logic         fillreq = 1'b0;
  logic         fillbusy;
  logic [31:0]  mem_address;
  logic         mem_rden;
  logic         mem_ack = 1'b0;
  logic [31:0]  mem_readdata = '0;
  logic         mem_readvalid = 1'b0;
  logic [127:0] linedata;
  logic [31:0]  lineaddr;
  logic         linevalid;
  logic         lineack = 1'b0;
`ifdef FILLBUFFER_EARLYWORD_EN
  logic         earlyword_valid;
  logic [31:0]  earlyword_data;
`endif

  always #5 clk = ~clk;

  mem_fillbuffer dut (
    .clk(clk), .resetn(resetn), .filladdr(filladdr), .fillreq(fillreq), .fillbusy(fillbusy),
    .mem_address(mem_address), .mem_rden(mem_rden), .mem_ack(mem_ack),
    .mem_readdata(mem_readdata), .mem_readvalid(mem_readvalid),
    .linedata(linedata), .lineaddr(lineaddr), .linevalid(linevalid), .lineack(lineack)
`ifdef FILLBUFFER_EARLYWORD_EN
    , .earlyword_valid(earlyword_valid), .earlyword_data(earlyword_data)
`endif
  );

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] line;
  } exp_t;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] line;
    int           gap;
    int           ackdly;
    int           hold;
    bit           inj;
    logic [31:0]  exp_addr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   errs = 0;
  int   checks = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_fill(input logic [31:0] addr, input logic [127:0] line, input int gap,
                         input int ackdly, input int hold, input bit inj,
                         input logic [31:0] exp_addr);
    exp_t e;
    int   idx;
    idx = int'(addr[3:2]);
    fillreq = 1'b1;
    filladdr = addr;
    e.addr = exp_addr;
    e.line = line;
    sb.push_back(e);
    tick;
    fillreq = 1'b0;
    filladdr = '0;
    chk("busy_in_req", fillbusy, 1);
    for (int i = 0; i < ackdly; i++) begin
      chk("rden_held", mem_rden, 1);
      chk("mem_address", mem_address, exp_addr);
      tick;
    end
    chk("rden_at_ack", mem_rden, 1);
    chk("mem_address_at_ack", mem_address, exp_addr);
    // A beat presented together with mem_ack must not be captured.
    mem_ack = 1'b1;
    mem_readvalid = 1'b1;
    mem_readdata = 32'hDEADBEEF;
    tick;
    mem_ack = 1'b0;
    mem_readvalid = 1'b0;
    chk("rden_after_ack", mem_rden, 0);
    if (inj) begin
      fillreq = 1'b1;
      filladdr = 32'h2000;
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        chk("linevalid_gap", linevalid, 0);
`ifdef FILLBUFFER_EARLYWORD_EN
        if (g > 0) chk("earlyword_gap", earlyword_valid, 0);
`endif
        tick;
      end
      mem_readvalid = 1'b1;
      mem_readdata = line[32*k +: 32];
      tick;
      mem_readvalid = 1'b0;
`ifdef FILLBUFFER_EARLYWORD_EN
      chk("earlyword_valid", earlyword_valid, (k == idx));
      if (k == idx) chk("earlyword_data", earlyword_data, line[32*k +: 32]);
`endif
      if (k < 3) begin
        chk("linevalid_early", linevalid, 0);
        chk("busy_collect", fillbusy, 1);
        chk("rden_collect", mem_rden, 0);
      end
    end
    chk("linevalid_rise", linevalid, 1);
    if (sb.size() == 0) begin
      checks++;
      errs++;
      $display("FAIL scoreboard_empty: got line with no expectation");
    end else begin
      e = sb.pop_front();
      chk("linedata", linedata, e.line);
      chk("lineaddr", lineaddr, e.addr);
    end
    for (int h = 0; h < hold; h++) begin
      lineack = 1'b0;
      tick;
      chk("linevalid_hold", linevalid, 1);
      chk("linedata_hold", linedata, e.line);
      chk("lineaddr_hold", lineaddr, e.addr);
      chk("rden_deliver", mem_rden, 0);
`ifdef FILLBUFFER_EARLYWORD_EN
      chk("earlyword_deliver", earlyword_valid, 0);
`endif
    end
    lineack = 1'b1;
    tick;
    lineack = 1'b0;
    fillreq = 1'b0;
    filladdr = '0;
    chk("linevalid_drop", linevalid, 0);
    chk("busy_drop", fillbusy, 0);
    if (inj) begin
      tick;
      chk("busy_no_refill", fillbusy, 0);
      chk("rden_no_refill", mem_rden, 0);
      chk("addr_not_2000", (mem_address != 32'h2000), 1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fillbusy"}, fillbusy, 0);
    chk({tag, "_rden"}, mem_rden, 0);
    chk({tag, "_linevalid"}, linevalid, 0);
    chk({tag, "_mem_address"}, mem_address, 0);
    chk({tag, "_lineaddr"}, lineaddr, 0);
    chk({tag, "_linedata"}, linedata, 0);
`ifdef FILLBUFFER_EARLYWORD_EN
    chk({tag, "_ew_valid"}, earlyword_valid, 0);
    chk({tag, "_ew_data"}, earlyword_data, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h1004, 128'h44444444_33333333_22222222_11111111, 0, 3, 0, 1'b0, 32'h1000};
    vecs[1] = '{32'h1004, 128'h44444444_33333333_22222222_11111111, 2, 3, 0, 1'b0, 32'h1000};
    vecs[2] = '{32'h100C, 128'hCAFEBABE_01234567_89ABCDEF_FEDCBA98, 1, 0, 5, 1'b1, 32'h1000};
    vecs[3] = '{32'hFFFFFFFF, 128'hA5A5A5A5_5A5A5A5A_00000000_FFFFFFFF, 0, 1, 1, 1'b0, 32'hFFFFFFF0};
    vecs[4] = '{32'h1008, 128'h44444444_33333333_22222222_11111111, 0, 2, 0, 1'b0, 32'h1000};

    // Reset: a request presented while in reset must be dropped.
    resetn = 1'b0;
    fillreq = 1'b1;
    filladdr = 32'h5555;
    tick;
    tick;
    chk_all_zero("reset");
    fillreq = 1'b0;
    filladdr = '0;
    resetn = 1'b1;
    tick;
    chk("idle_after_reset", fillbusy, 0);

    // Stray ack while idle has no effect.
    lineack = 1'b1;
    tick;
    lineack = 1'b0;
    chk("stray_lineack", fillbusy | linevalid, 0);

    for (int i = 0; i < 5; i++)
      do_fill(vecs[i].addr, vecs[i].line, vecs[i].gap, vecs[i].ackdly, vecs[i].hold,
              vecs[i].inj, vecs[i].exp_addr);

    // Reset mid-fill after two beats, then stray beats from the abandoned read.
    fillreq = 1'b1;
    filladdr = 32'h1004;
    tick;
    fillreq = 1'b0;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_readvalid = 1'b1;
      mem_readdata = 32'hBAD00000 + k;
      tick;
    end
    mem_readvalid = 1'b0;
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    chk_all_zero("midreset");
    for (int k = 0; k < 2; k++) begin
      mem_readvalid = 1'b1;
      mem_readdata = 32'hBAD10000 + k;
      tick;
      chk("stray_busy", fillbusy, 0);
      chk("stray_linevalid", linevalid, 0);
      chk("stray_linedata", linedata, 0);
    end
    mem_readvalid = 1'b0;
    do_fill(32'h3000, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 0, 1, 0, 1'b0, 32'h3000);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
